// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_time_counter
//  Purpose  : BCD time-of-day counter with hour/minute set mode and carry strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_time_counter #(
   parameter int INIT_HOUR = 0,
   parameter int INIT_MIN  = 0
) (
   input  logic       div_clk,
   input  logic       rst_n,
   input  logic       cnt_en,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [3:0] secL,
   output logic [3:0] secH,
   output logic [3:0] minL,
   output logic [3:0] minH,
   output logic [3:0] hourL,
   output logic [3:0] hourH,
   output logic [1:0] set_state,
   output logic       min_carry,
   output logic       hour_carry,
   output logic       day_carry
);

   localparam logic [3:0] c_INIT_HH = 4'(INIT_HOUR / 10);
   localparam logic [3:0] c_INIT_HL = 4'(INIT_HOUR % 10);
   localparam logic [3:0] c_INIT_MH = 4'(INIT_MIN / 10);
   localparam logic [3:0] c_INIT_ML = 4'(INIT_MIN % 10);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_SET_HOUR = 2'b01,
      ST_SET_MIN  = 2'b10
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_sec_l, r_sec_h, r_min_l, r_min_h, r_hour_l, r_hour_h;
   logic [3:0] w_sec_l_nxt, w_sec_h_nxt, w_min_l_nxt, w_min_h_nxt, w_hour_l_nxt, w_hour_h_nxt;
   logic       r_min_carry, r_hour_carry, r_day_carry;
   logic       w_min_carry_nxt, w_hour_carry_nxt, w_day_carry_nxt;

   // Two-digit BCD increments, returned as {tens, units}
   function automatic logic [7:0] f_inc_hour(input logic [3:0] hh, input logic [3:0] hl);
      logic [7:0] res;
      if (hh == 4'd2 && hl == 4'd3)
         res = 8'h00;
      else if (hl == 4'd9)
         res = {hh + 4'd1, 4'd0};
      else
         res = {hh, hl + 4'd1};
      return res;
   endfunction

   function automatic logic [7:0] f_inc_min(input logic [3:0] mh, input logic [3:0] ml);
      logic [7:0] res;
      if (ml != 4'd9)
         res = {mh, ml + 4'd1};
      else if (mh != 4'd5)
         res = {mh + 4'd1, 4'd0};
      else
         res = 8'h00;
      return res;
   endfunction

   always_comb begin
      w_state_nxt      = r_state;
      w_sec_l_nxt      = r_sec_l;
      w_sec_h_nxt      = r_sec_h;
      w_min_l_nxt      = r_min_l;
      w_min_h_nxt      = r_min_h;
      w_hour_l_nxt     = r_hour_l;
      w_hour_h_nxt     = r_hour_h;
      w_min_carry_nxt  = 1'b0;
      w_hour_carry_nxt = 1'b0;
      w_day_carry_nxt  = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (key_mode) begin
               w_state_nxt = ST_SET_HOUR;
               w_sec_l_nxt = 4'd0;
               w_sec_h_nxt = 4'd0;
            end else if (cnt_en) begin
               if (r_sec_l != 4'd9) begin
                  w_sec_l_nxt = r_sec_l + 4'd1;
               end else begin
                  w_sec_l_nxt = 4'd0;
                  if (r_sec_h != 4'd5) begin
                     w_sec_h_nxt = r_sec_h + 4'd1;
                  end else begin
                     w_sec_h_nxt     = 4'd0;
                     w_min_carry_nxt = 1'b1;
                     {w_min_h_nxt, w_min_l_nxt} = f_inc_min(r_min_h, r_min_l);
                     if (r_min_h == 4'd5 && r_min_l == 4'd9) begin
                        w_hour_carry_nxt = 1'b1;
                        {w_hour_h_nxt, w_hour_l_nxt} = f_inc_hour(r_hour_h, r_hour_l);
                        w_day_carry_nxt = (r_hour_h == 4'd2 && r_hour_l == 4'd3);
                     end
                  end
               end
            end
         end
         ST_SET_HOUR: begin
            if (key_mode)
               w_state_nxt = ST_SET_MIN;
            else if (key_inc)
               {w_hour_h_nxt, w_hour_l_nxt} = f_inc_hour(r_hour_h, r_hour_l);
         end
         ST_SET_MIN: begin
            // Minute edits wrap locally and never ripple into hours
            if (key_mode)
               w_state_nxt = ST_RUN;
            else if (key_inc)
               {w_min_h_nxt, w_min_l_nxt} = f_inc_min(r_min_h, r_min_l);
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge div_clk) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_sec_l      <= 4'd0;
         r_sec_h      <= 4'd0;
         r_min_l      <= c_INIT_ML;
         r_min_h      <= c_INIT_MH;
         r_hour_l     <= c_INIT_HL;
         r_hour_h     <= c_INIT_HH;
         r_min_carry  <= 1'b0;
         r_hour_carry <= 1'b0;
         r_day_carry  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sec_l      <= w_sec_l_nxt;
         r_sec_h      <= w_sec_h_nxt;
         r_min_l      <= w_min_l_nxt;
         r_min_h      <= w_min_h_nxt;
         r_hour_l     <= w_hour_l_nxt;
         r_hour_h     <= w_hour_h_nxt;
         r_min_carry  <= w_min_carry_nxt;
         r_hour_carry <= w_hour_carry_nxt;
         r_day_carry  <= w_day_carry_nxt;
      end
   end

   assign secL       = r_sec_l;
   assign secH       = r_sec_h;
   assign minL       = r_min_l;
   assign minH       = r_min_h;
   assign hourL      = r_hour_l;
   assign hourH      = r_hour_h;
   assign set_state  = r_state;
   assign min_carry  = r_min_carry;
   assign hour_carry = r_hour_carry;
   assign day_carry  = r_day_carry;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_time_counter
//  Purpose  : Self-checking bench for bcd_time_counter against a seconds-of-day model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_time_counter;

   localparam int c_DAY = 86400;
   localparam int c_T1  = 9 * 3600 + 5 * 60;

   logic       div_clk, rst_n, cnt_en, key_mode, key_inc;
   logic [3:0] d0_sl, d0_sh, d0_ml, d0_mh, d0_hl, d0_hh;
   logic [3:0] d1_sl, d1_sh, d1_ml, d1_mh, d1_hl, d1_hh;
   logic [1:0] d0_st, d1_st;
   logic       d0_mc, d0_hc, d0_dc, d1_mc, d1_hc, d1_dc;

   bcd_time_counter #(.INIT_HOUR(0), .INIT_MIN(0)) u_dut0 (
      .div_clk(div_clk), .rst_n(rst_n), .cnt_en(cnt_en), .key_mode(key_mode), .key_inc(key_inc),
      .secL(d0_sl), .secH(d0_sh), .minL(d0_ml), .minH(d0_mh), .hourL(d0_hl), .hourH(d0_hh),
      .set_state(d0_st), .min_carry(d0_mc), .hour_carry(d0_hc), .day_carry(d0_dc)
   );

   bcd_time_counter #(.INIT_HOUR(9), .INIT_MIN(5)) u_dut1 (
      .div_clk(div_clk), .rst_n(rst_n), .cnt_en(cnt_en), .key_mode(key_mode), .key_inc(key_inc),
      .secL(d1_sl), .secH(d1_sh), .minL(d1_ml), .minH(d1_mh), .hourL(d1_hl), .hourH(d1_hh),
      .set_state(d1_st), .min_carry(d1_mc), .hour_carry(d1_hc), .day_carry(d1_dc)
   );

   initial div_clk = 1'b0;
   always #5 div_clk = ~div_clk;

   int checks   = 0;
   int failures = 0;

   // Model: time as seconds-of-day per instance, shared mode (0 run, 1 hour, 2 min)
   int t [2];
   int mst = 0;
   bit mc [2];
   bit hc [2];
   bit dc [2];
   bit valid = 1'b0;

   always @(posedge div_clk) begin
      for (int k = 0; k < 2; k++) begin
         mc[k] = 1'b0; hc[k] = 1'b0; dc[k] = 1'b0;
      end
      if (!rst_n) begin
         mst = 0; t[0] = 0; t[1] = c_T1; valid = 1'b1;
      end else begin
         case (mst)
            0: if (key_mode) begin
                  mst = 1;
                  for (int k = 0; k < 2; k++) t[k] = t[k] - t[k] % 60;
               end else if (cnt_en) begin
                  for (int k = 0; k < 2; k++) begin
                     t[k]  = (t[k] + 1) % c_DAY;
                     mc[k] = (t[k] % 60 == 0);
                     hc[k] = (t[k] % 3600 == 0);
                     dc[k] = (t[k] == 0);
                  end
               end
            1: if (key_mode) mst = 2;
               else if (key_inc)
                  for (int k = 0; k < 2; k++) t[k] = (t[k] + 3600) % c_DAY;
            default: if (key_mode) mst = 0;
               else if (key_inc)
                  for (int k = 0; k < 2; k++) begin
                     int m;
                     m    = (t[k] / 60) % 60;
                     t[k] = t[k] - m * 60 + ((m + 1) % 60) * 60;
                  end
         endcase
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at t=%0t: actual=%0d required=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_dut(input string p, input int k,
                          input logic [3:0] sl, input logic [3:0] sh, input logic [3:0] ml,
                          input logic [3:0] mh, input logic [3:0] hl, input logic [3:0] hh,
                          input logic [1:0] st, input logic c1, input logic c2, input logic c3);
      int h, m, s;
      h = t[k] / 3600; m = (t[k] / 60) % 60; s = t[k] % 60;
      chk({p, ".secL"},  int'(sl), s % 10);
      chk({p, ".secH"},  int'(sh), s / 10);
      chk({p, ".minL"},  int'(ml), m % 10);
      chk({p, ".minH"},  int'(mh), m / 10);
      chk({p, ".hourL"}, int'(hl), h % 10);
      chk({p, ".hourH"}, int'(hh), h / 10);
      chk({p, ".set_state"},  int'(st), mst);
      chk({p, ".min_carry"},  int'(c1), int'(mc[k]));
      chk({p, ".hour_carry"}, int'(c2), int'(hc[k]));
      chk({p, ".day_carry"},  int'(c3), int'(dc[k]));
   endtask

   always @(negedge div_clk) begin
      if (valid) begin
         cmp_dut("dut0", 0, d0_sl, d0_sh, d0_ml, d0_mh, d0_hl, d0_hh, d0_st, d0_mc, d0_hc, d0_dc);
         cmp_dut("dut1", 1, d1_sl, d1_sh, d1_ml, d1_mh, d1_hl, d1_hh, d1_st, d1_mc, d1_hc, d1_dc);
      end
   end

   task automatic cyc(input logic r, input logic m, input logic i, input logic e);
      rst_n = r; key_mode = m; key_inc = i; cnt_en = e;
      @(negedge div_clk);
   endtask

   // Literal expectation on dut0 (hand-computed), pins the model as well
   task automatic lit(input string nm, input int hh, input int mm, input int ss, input int st,
                      input int c1, input int c2, input int c3);
      chk({nm, ".time"}, int'({d0_hh, d0_hl, d0_mh, d0_ml, d0_sh, d0_sl}),
          ((hh / 10) << 20) | ((hh % 10) << 16) | ((mm / 10) << 12) | ((mm % 10) << 8) |
          ((ss / 10) << 4) | (ss % 10));
      chk({nm, ".state"}, int'(d0_st), st);
      chk({nm, ".carries"}, int'({d0_mc, d0_hc, d0_dc}), (c1 << 2) | (c2 << 1) | c3);
   endtask

   task automatic set_time(input int h, input int m);
      int hcur, mcur;
      cyc(1, 1, 0, 0);
      hcur = t[0] / 3600;
      repeat ((h - hcur + 24) % 24) cyc(1, 0, 1, 0);
      cyc(1, 1, 0, 0);
      mcur = (t[0] / 60) % 60;
      repeat ((m - mcur + 60) % 60) cyc(1, 0, 1, 0);
      cyc(1, 1, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0; cnt_en = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
      @(negedge div_clk);
      cyc(0, 0, 0, 1);
      lit("reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset.dut1", int'({d1_hh, d1_hl, d1_mh, d1_ml, d1_sh, d1_sl}), 32'h090500);
      repeat (3) cyc(1, 0, 0, 1);
      lit("count3", 0, 0, 3, 0, 0, 0, 0);

      set_time(0, 0);
      lit("preset", 0, 0, 0, 0, 0, 0, 0);
      repeat (59) cyc(1, 0, 0, 1);
      lit("sec59", 0, 0, 59, 0, 0, 0, 0);
      cyc(1, 0, 0, 1);
      lit("min_wrap", 0, 1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1);
      lit("min_wrap_next", 0, 1, 1, 0, 0, 0, 0);

      set_time(23, 59);
      repeat (59) cyc(1, 0, 0, 1);
      lit("pre_midnight", 23, 59, 59, 0, 0, 0, 0);
      cyc(1, 0, 0, 1);
      lit("midnight", 0, 0, 0, 0, 1, 1, 1);
      cyc(1, 0, 0, 1);
      lit("after_midnight", 0, 0, 1, 0, 0, 0, 0);

      set_time(12, 34);
      repeat (56) cyc(1, 0, 0, 1);
      lit("t123456", 12, 34, 56, 0, 0, 0, 0);
      cyc(1, 1, 0, 1);
      lit("enter_set", 12, 34, 0, 1, 0, 0, 0);
      repeat (12) cyc(1, 0, 1, 1);
      lit("hour_wrap", 0, 34, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (26) cyc(1, 0, 1, 1);
      lit("min_set_wrap", 0, 0, 0, 2, 0, 0, 0);
      cyc(1, 1, 0, 0);

      cyc(1, 0, 1, 0);
      lit("inc_in_run", 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 0);
      lit("mode_wins", 0, 0, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (7) cyc(1, 0, 0, 1);
      repeat (5) cyc(1, 0, 0, 0);
      lit("frozen", 0, 0, 7, 0, 0, 0, 0);

      cyc(1, 1, 0, 0);
      repeat (7) cyc(1, 0, 1, 0);
      cyc(1, 1, 0, 0);
      repeat (45) cyc(1, 0, 1, 0);
      lit("edited", 7, 45, 0, 2, 0, 0, 0);
      cyc(0, 0, 1, 1);
      lit("reset_in_set", 0, 0, 0, 0, 0, 0, 0);
      chk("reset_in_set.dut1", int'({d1_hh, d1_hl, d1_mh, d1_ml, d1_sh, d1_sl}), 32'h090500);

      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
